// File: rtl/line_scan_sequencer_if.sv
// ADC handshake and pixel stream bundle for the line-scan sequencer.
// master = sequencer side, slave = ADC control / pixel consumer side.
interface line_scan_sequencer_if #(
    parameter int unsigned IDX_W = 8
);
    logic             adc_start;
    logic             adc_done;
    logic [11:0]      adc_data1;
    logic [11:0]      adc_data2;
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic [11:0]      pixel_data1;
    logic [11:0]      pixel_data2;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data1,
        input  adc_data2,
        output pixel_valid,
        output pixel_index,
        output pixel_data1,
        output pixel_data2
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data1,
        output adc_data2,
        input  pixel_valid,
        input  pixel_index,
        input  pixel_data1,
        input  pixel_data2
    );
endinterface

// File: rtl/line_scan_sequencer.sv
// Line-scan sensor frame sequencer: SI / sensor clock generation, one ADC conversion
// per pixel, indexed pixel stream and a programmable integration gap between frames.
module line_scan_sequencer #(
    parameter int unsigned NUM_PIXELS  = 128,
    parameter int unsigned HALF_PERIOD = 10,
    parameter int unsigned ADC_TIMEOUT = 64,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                         clk_20M,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [15:0]                  exposure_cycles,
    line_scan_sequencer_if.master        bus,
    output logic                         SI,
    output logic                         sensor_clk_int,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         adc_timeout
);
    localparam int unsigned PhaseW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned ConvW  = $clog2(ADC_TIMEOUT + 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(HALF_PERIOD - 1);
    localparam logic [IDX_W-1:0]  LastPix   = IDX_W'(NUM_PIXELS - 1);
    localparam logic [ConvW-1:0]  ConvLimit = ConvW'(ADC_TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StSiLow, StSiHigh, StPixLow, StPixConv, StPixHigh, StTermHigh, StTermLow, StExpose
    } state_e;

    state_e            state_q, state_d, gap_next;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]  pix_cnt_q, idx_q;
    logic [ConvW-1:0]  conv_cnt_q;
    logic              conv_pend_q;
    logic [15:0]       exp_q;
    logic [16:0]       exp_cnt_q;
    logic              sclk_q, si_q, pv_q, tmo_q;
    logic [11:0]       data1_q, data2_q;
    logic              phase_end, conv_hit, conv_tmo, conv_ok;
    logic              adc_start_int;

    // State register
    always_ff @(posedge clk_20M) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and phase counter
    always_comb begin
        phase_end = (phase_q == PhaseLast);
        conv_hit  = conv_pend_q && bus.adc_done;
        conv_tmo  = conv_pend_q && !bus.adc_done && (conv_cnt_q == ConvLimit);
        conv_ok   = !conv_pend_q || conv_hit || conv_tmo;
        gap_next  = continuous ? StSiLow : StIdle;
        state_d   = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StSiLow;
            StSiLow:    if (phase_end) state_d = StSiHigh;
            StSiHigh:   if (phase_end) state_d = StPixLow;
            StPixLow:   state_d = StPixConv;
            // The last converted pixel is followed by the terminating clock, not a pixel clock.
            StPixConv:  if (phase_end && conv_ok) begin
                            state_d = (pix_cnt_q == LastPix) ? StTermHigh : StPixHigh;
                        end
            StPixHigh:  if (phase_end) state_d = StPixLow;
            StTermHigh: if (phase_end) state_d = StTermLow;
            StTermLow:  if (phase_end) state_d = (exp_q == '0) ? gap_next : StExpose;
            StExpose:   if (phase_end && exp_cnt_q == '0) state_d = gap_next;
            default:    state_d = StIdle;
        endcase

        phase_d = phase_q;
        if (state_q == StIdle) begin
            phase_d = '0;
        end else if (state_q == StPixConv) begin
            // Low phase stretches while a conversion is still outstanding.
            if (state_d != StPixConv)  phase_d = '0;
            else if (!phase_end)       phase_d = phase_q + PhaseW'(1);
        end else begin
            phase_d = phase_end ? '0 : phase_q + PhaseW'(1);
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != StIdle);
        adc_start_int  = (state_q == StPixLow);
        frame_done     = (state_q == StTermLow) && phase_end;
        SI             = si_q;
        sensor_clk_int = sclk_q;
        adc_timeout    = tmo_q;
    end

    assign bus.adc_start   = adc_start_int;
    assign bus.pixel_valid = pv_q;
    assign bus.pixel_index = idx_q;
    assign bus.pixel_data1 = data1_q;
    assign bus.pixel_data2 = data2_q;

    // Datapath
    always_ff @(posedge clk_20M) begin
        if (!reset) begin
            phase_q     <= '0;
            pix_cnt_q   <= '0;
            conv_cnt_q  <= '0;
            conv_pend_q <= 1'b0;
            exp_q       <= '0;
            exp_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            si_q        <= 1'b0;
            pv_q        <= 1'b0;
            idx_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            tmo_q       <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sclk_q  <= state_d inside {StSiHigh, StPixHigh, StTermHigh};
            si_q    <= state_d inside {StSiLow, StSiHigh};
            pv_q    <= conv_hit || conv_tmo;
            if (conv_hit || conv_tmo) begin
                idx_q   <= pix_cnt_q;
                data1_q <= conv_hit ? bus.adc_data1 : 12'd0;
                data2_q <= conv_hit ? bus.adc_data2 : 12'd0;
            end
            if (conv_tmo) tmo_q <= 1'b1;

            if (state_q == StPixLow) begin
                conv_pend_q <= 1'b1;
                conv_cnt_q  <= ConvW'(1);
            end else if (conv_hit || conv_tmo) begin
                conv_pend_q <= 1'b0;
            end else if (conv_pend_q) begin
                conv_cnt_q <= conv_cnt_q + ConvW'(1);
            end

            if (state_d == StSiLow && state_q != StSiLow) begin
                exp_q     <= exposure_cycles;
                pix_cnt_q <= '0;
            end else if (state_q == StPixConv && state_d != StPixConv) begin
                pix_cnt_q <= pix_cnt_q + IDX_W'(1);
            end

            // Gap counted in half periods; remaining-minus-one so zero marks the last phase.
            if (state_d == StExpose && state_q != StExpose) begin
                exp_cnt_q <= {exp_q, 1'b0} - 17'd1;
            end else if (state_q == StExpose && phase_end && exp_cnt_q != '0) begin
                exp_cnt_q <= exp_cnt_q - 17'd1;
            end
        end
    end
endmodule

// File: tb/tb_line_scan_sequencer.sv
// Directed bench for line_scan_sequencer: frame timing, pixel stream, ADC timeout,
// continuous mode, mid-frame reset and start-while-busy.
`timescale 1ns/1ps
module tb_line_scan_sequencer;
    localparam int unsigned NP  = 128;
    localparam int unsigned HP  = 10;
    localparam int unsigned TMO = 64;

    logic        clk_20M = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] exposure_cycles = 16'd0;
    logic        SI, sensor_clk_int, frame_done, busy, adc_timeout;

    line_scan_sequencer_if #(.IDX_W(8)) bus ();

    line_scan_sequencer #(
        .NUM_PIXELS (NP),
        .HALF_PERIOD(HP),
        .ADC_TIMEOUT(TMO),
        .IDX_W      (8)
    ) dut (
        .clk_20M        (clk_20M),
        .reset          (reset),
        .start          (start),
        .continuous     (continuous),
        .exposure_cycles(exposure_cycles),
        .bus            (bus),
        .SI             (SI),
        .sensor_clk_int (sensor_clk_int),
        .frame_done     (frame_done),
        .busy           (busy),
        .adc_timeout    (adc_timeout)
    );

    always #25 clk_20M = ~clk_20M;

    int checks = 0;
    int errors = 0;

    // ADC responder settings
    int adc_lat = 8;
    int late_lat = 66;
    int silent_idx = -1;
    int dly = 0, seq = 0, pend = 0;

    // Monitor statistics
    int cyc = 0, pv_count = 0, fd_count = 0, si_rises = 0, si_cycles = 0, adc_starts = 0;
    int rises = 0, high_run = 0, low_run = 0, min_high, max_high, min_low, max_low;
    int gap_cnt = 0, first_gap = -1, idle_gap = -1, n_gap = 0;
    int start_tmo_cyc = -1, tmo_cyc = -1;
    bit gap_on = 0, seen_fall = 0, si_at_rise = 0;
    bit prev_sclk = 0, prev_si = 0, prev_tmo = 0;
    int cap_idx [512];
    int cap_d1 [512];
    int cap_d2 [512];

    task automatic clear_stats();
        pv_count = 0; fd_count = 0; si_rises = 0; si_cycles = 0; adc_starts = 0;
        rises = 0; high_run = 0; low_run = 0; seen_fall = 0; si_at_rise = 0;
        min_high = 1 << 30; max_high = 0; min_low = 1 << 30; max_low = 0;
        gap_on = 0; gap_cnt = 0; first_gap = -1; idle_gap = -1; n_gap = 0;
        start_tmo_cyc = -1; tmo_cyc = -1;
    endtask

    initial begin : adc_model
        bus.adc_done = 1'b0;
        bus.adc_data1 = 12'd0;
        bus.adc_data2 = 12'd0;
        forever begin
            @(posedge clk_20M); #1;
            bus.adc_done = 1'b0;
            if (SI) seq = 0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    bus.adc_done = 1'b1;
                    if (pend == silent_idx) begin
                        bus.adc_data1 = 12'hABC;
                        bus.adc_data2 = 12'h123;
                    end else begin
                        bus.adc_data1 = 12'(pend);
                        bus.adc_data2 = 12'hFFF - 12'(pend);
                    end
                end
            end
            if (bus.adc_start) begin
                pend = seq;
                seq++;
                dly = (pend == silent_idx) ? late_lat : adc_lat;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk_20M); #1;
            cyc++;
            if (bus.pixel_valid) begin
                if (pv_count < 512) begin
                    cap_idx[pv_count] = int'(bus.pixel_index);
                    cap_d1[pv_count]  = int'(bus.pixel_data1);
                    cap_d2[pv_count]  = int'(bus.pixel_data2);
                end
                pv_count++;
            end
            if (frame_done) begin
                fd_count++;
                gap_on = 1;
                gap_cnt = 0;
            end else if (gap_on) begin
                if (SI) begin
                    if (n_gap == 0) first_gap = gap_cnt;
                    n_gap++;
                    gap_on = 0;
                end else if (!busy) begin
                    idle_gap = gap_cnt;
                    gap_on = 0;
                end else if (!sensor_clk_int) begin
                    gap_cnt++;
                end
            end
            if (SI && !prev_si) si_rises++;
            if (SI) si_cycles++;
            if (bus.adc_start) begin
                if (adc_starts == silent_idx) start_tmo_cyc = cyc;
                adc_starts++;
            end
            if (adc_timeout && !prev_tmo) tmo_cyc = cyc;
            if (sensor_clk_int) begin
                if (!prev_sclk) begin
                    rises++;
                    if (rises == 1) si_at_rise = SI;
                    if (seen_fall) begin
                        if (low_run < min_low) min_low = low_run;
                        if (low_run > max_low) max_low = low_run;
                    end
                end
                high_run++;
            end else begin
                if (prev_sclk) begin
                    if (high_run < min_high) min_high = high_run;
                    if (high_run > max_high) max_high = high_run;
                    high_run = 0;
                    seen_fall = 1;
                    low_run = 0;
                end
                low_run++;
            end
            prev_si = SI;
            prev_tmo = adc_timeout;
            prev_sclk = sensor_clk_int;
        end
    end

    // Reference pixel stream: index k%NP, data1=index, data2=0xFFF-index, zero for a timed-out pixel.
    function automatic int bad_pixels(input int n, input int silent);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            int idx = k % NP;
            int e1 = (idx == silent) ? 0 : idx;
            int e2 = (idx == silent) ? 0 : 4095 - idx;
            if (cap_idx[k] != idx || cap_d1[k] != e1 || cap_d2[k] != e2) bad++;
        end
        return bad;
    endfunction

    task automatic pulse_start();
        @(negedge clk_20M); start = 1'b1;
        @(negedge clk_20M); start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_20M);
            ok = !busy;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_wait_idle: busy still %0b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        logic [38:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clk_20M);
        v = {SI, sensor_clk_int, bus.adc_start, bus.pixel_valid, bus.pixel_index, bus.pixel_data1,
             bus.pixel_data2, frame_done, busy, adc_timeout};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        start = 1'b1;
        @(negedge clk_20M);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%0b, required 0", busy);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk_20M);
        checks++;
        if (busy !== 1'b0 || SI !== 1'b0 || sensor_clk_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b SI=%0b sclk=%0b, required 0 0 0", busy, SI, sensor_clk_int);
        end
    endtask

    task automatic test_single_frame();
        int bad;
        clear_stats();
        adc_lat = 8;
        pulse_start();
        wait_idle(6000, "single");
        bad = bad_pixels(NP, -1);
        checks++;
        if (pv_count !== NP) begin errors++; $display("FAIL single_pv_count: got %0d, required %0d", pv_count, NP); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL single_pixel_data: %0d bad pixels, required 0", bad); end
        checks++;
        if (rises !== NP + 1) begin errors++; $display("FAIL single_sclk_rises: got %0d, required %0d", rises, NP + 1); end
        checks++;
        if (si_cycles !== 2 * HP) begin errors++; $display("FAIL single_si_width: got %0d, required %0d", si_cycles, 2 * HP); end
        checks++;
        if (si_at_rise !== 1'b1) begin errors++; $display("FAIL single_si_spans_rise: got %0b, required 1", si_at_rise); end
        checks++;
        if (fd_count !== 1) begin errors++; $display("FAIL single_frame_done: got %0d, required 1", fd_count); end
        checks++;
        if (adc_starts !== NP) begin errors++; $display("FAIL single_adc_starts: got %0d, required %0d", adc_starts, NP); end
        checks++;
        if (min_low !== HP || max_low !== HP) begin
            errors++; $display("FAIL single_low_phase: min %0d max %0d, required %0d", min_low, max_low, HP);
        end
        checks++;
        if (min_high !== HP || max_high !== HP) begin
            errors++; $display("FAIL single_high_phase: min %0d max %0d, required %0d", min_high, max_high, HP);
        end
        checks++;
        if (adc_timeout !== 1'b0) begin errors++; $display("FAIL single_no_timeout: got %0b, required 0", adc_timeout); end
    endtask

    task automatic test_slow_adc();
        int bad;
        clear_stats();
        adc_lat = 30;
        pulse_start();
        wait_idle(12000, "slow");
        adc_lat = 8;
        bad = bad_pixels(NP, -1);
        checks++;
        if (pv_count !== NP) begin errors++; $display("FAIL slow_pv_count: got %0d, required %0d", pv_count, NP); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL slow_pixel_data: %0d bad pixels, required 0", bad); end
        checks++;
        if (min_low < 30) begin errors++; $display("FAIL slow_low_stretch: min low %0d, required >= 30", min_low); end
        checks++;
        if (min_high !== HP || max_high !== HP) begin
            errors++; $display("FAIL slow_high_phase: min %0d max %0d, required %0d", min_high, max_high, HP);
        end
        checks++;
        if (rises !== NP + 1) begin errors++; $display("FAIL slow_sclk_rises: got %0d, required %0d", rises, NP + 1); end
    endtask

    task automatic test_timeout();
        int bad;
        clear_stats();
        silent_idx = 5;
        pulse_start();
        wait_idle(8000, "timeout");
        bad = bad_pixels(NP, 5);
        checks++;
        if (adc_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b, required 1", adc_timeout); end
        checks++;
        if (tmo_cyc - start_tmo_cyc < TMO || tmo_cyc - start_tmo_cyc > TMO + 1) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles, required %0d..%0d", tmo_cyc - start_tmo_cyc, TMO, TMO + 1);
        end
        checks++;
        if (pv_count !== NP) begin errors++; $display("FAIL timeout_pv_count: got %0d, required %0d", pv_count, NP); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL timeout_pixel_data: %0d bad pixels, required 0", bad); end
        checks++;
        if (fd_count !== 1) begin errors++; $display("FAIL timeout_frame_done: got %0d, required 1", fd_count); end
        silent_idx = -1;
    endtask

    task automatic test_continuous();
        int bad;
        bit ok = 0;
        clear_stats();
        continuous = 1'b1;
        exposure_cycles = 16'd3;
        pulse_start();
        for (int i = 0; i < 12000 && !ok; i++) begin
            @(negedge clk_20M);
            ok = (pv_count >= NP + 10);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL cont_second_frame: pv_count %0d, required >= %0d", pv_count, NP + 10); end
        continuous = 1'b0;
        wait_idle(6000, "cont");
        exposure_cycles = 16'd0;
        bad = bad_pixels(2 * NP, -1);
        checks++;
        if (first_gap !== 2 * 3 * HP) begin errors++; $display("FAIL cont_gap: got %0d, required %0d", first_gap, 2 * 3 * HP); end
        checks++;
        if (idle_gap !== 2 * 3 * HP) begin errors++; $display("FAIL cont_gap_to_idle: got %0d, required %0d", idle_gap, 2 * 3 * HP); end
        checks++;
        if (fd_count !== 2) begin errors++; $display("FAIL cont_frame_done: got %0d, required 2", fd_count); end
        checks++;
        if (pv_count !== 2 * NP) begin errors++; $display("FAIL cont_pv_count: got %0d, required %0d", pv_count, 2 * NP); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL cont_pixel_data: %0d bad pixels, required 0", bad); end
        checks++;
        if (si_rises !== 2) begin errors++; $display("FAIL cont_si_rises: got %0d, required 2", si_rises); end
    endtask

    task automatic test_reset_mid_frame();
        logic [38:0] v;
        int pv_hold, bad;
        bit ok = 0;
        clear_stats();
        pulse_start();
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk_20M);
            ok = (pv_count >= 40);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_reach_pixel40: pv_count %0d, required >= 40", pv_count); end
        reset = 1'b0;
        @(negedge clk_20M);
        v = {SI, sensor_clk_int, bus.adc_start, bus.pixel_valid, bus.pixel_index, bus.pixel_data1,
             bus.pixel_data2, frame_done, busy, adc_timeout};
        reset = 1'b1;
        checks++;
        if (v !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h, required 0", v); end
        pv_hold = pv_count;
        repeat (300) @(negedge clk_20M);
        checks++;
        if (pv_count !== pv_hold || fd_count !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: pv %0d fd %0d busy %0b, required pv %0d fd 0 busy 0",
                     pv_count, fd_count, busy, pv_hold);
        end
        clear_stats();
        pulse_start();
        wait_idle(6000, "rstmid");
        bad = bad_pixels(NP, -1);
        checks++;
        if (pv_count !== NP || bad !== 0) begin
            errors++; $display("FAIL rstmid_new_frame: pv %0d bad %0d, required %0d and 0", pv_count, bad, NP);
        end
        checks++;
        if (fd_count !== 1) begin errors++; $display("FAIL rstmid_frame_done: got %0d, required 1", fd_count); end
    endtask

    task automatic test_start_while_busy();
        bit ok = 0;
        clear_stats();
        pulse_start();
        repeat (100) @(negedge clk_20M);
        pulse_start();
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk_20M);
            ok = (pv_count >= 64);
        end
        pulse_start();
        wait_idle(6000, "busystart");
        repeat (200) @(negedge clk_20M);
        checks++;
        if (fd_count !== 1) begin errors++; $display("FAIL busystart_frame_done: got %0d, required 1", fd_count); end
        checks++;
        if (pv_count !== NP) begin errors++; $display("FAIL busystart_pv_count: got %0d, required %0d", pv_count, NP); end
        checks++;
        if (si_rises !== 1) begin errors++; $display("FAIL busystart_si_rises: got %0d, required 1", si_rises); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busystart_idle: busy %0b, required 0", busy); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_frame();
        test_slow_adc();
        test_timeout();
        test_continuous();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
